// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operation sequencer: opcodes, FSM states,
// iteration count and small opcode helpers.
package alu_pkg;

    // Number of shift-add / shift-subtract steps for a 4-bit operand.
    localparam int unsigned ITER_STEPS = 4;

    // Opcode map; 12..15 are illegal.
    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_NAND = 4'd1;
    localparam logic [3:0] OP_OR   = 4'd2;
    localparam logic [3:0] OP_NOR  = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_XNOR = 4'd5;
    localparam logic [3:0] OP_NOT  = 4'd6;
    localparam logic [3:0] OP_SHL  = 4'd7;
    localparam logic [3:0] OP_ADD  = 4'd8;
    localparam logic [3:0] OP_SUB  = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;
    localparam logic [3:0] OP_DIV  = 4'd11;

    // Sequencer FSM states.
    typedef enum logic [1:0] {
        IDLE,
        ITER,
        DONE
    } state_t;

    // Which iterative algorithm the iteration unit runs.
    typedef enum logic {
        MODE_MUL,
        MODE_DIV
    } iter_mode_t;

    // True for opcodes outside the defined map.
    function automatic logic is_illegal_op(input logic [3:0] op);
        return op > OP_DIV;
    endfunction

    // True when the request needs the multi-cycle iteration unit.
    // DIV by zero is resolved immediately and never iterates.
    function automatic logic needs_iteration(input logic [3:0] op, input logic b_is_zero);
        return (op == OP_MUL) || ((op == OP_DIV) && !b_is_zero);
    endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative multiply / divide engine. MUL is an LSB-first shift-add over the
// multiplier bits; DIV is an MSB-first restoring shift-subtract. Both take
// ITER_STEPS cycles after start; done is asserted during the final step and
// result then carries the value produced by that step.
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  iter_mode_t         mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] result
);

    localparam int unsigned CW = $clog2(ITER_STEPS);
    localparam logic [CW-1:0] LAST_STEP = CW'(ITER_STEPS - 1);

    logic               busy;
    iter_mode_t         mode_q;
    logic [CW-1:0]      step;

    // Multiply state: accumulator, left-shifting multiplicand, right-shifting multiplier.
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;

    // Divide state: partial remainder, quotient/dividend shift register, divisor.
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   divisor;

    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH:0]     trial;
    logic [WIDTH:0]     trial_diff;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   quo_next;

    // One step of each algorithm, evaluated from the current registers.
    always_comb begin
        acc_next   = acc + (mplier[0] ? mcand : '0);
        trial      = {rem, quo[WIDTH-1]};
        trial_diff = trial - {1'b0, divisor};
        if (trial >= {1'b0, divisor}) begin
            rem_next = trial_diff[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = trial[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end

    // Final step is visible combinationally so the caller can register it
    // on the same edge that retires the iteration.
    always_comb begin
        done   = busy && (step == LAST_STEP);
        result = (mode_q == MODE_DIV) ? {rem_next, quo_next} : acc_next;
    end

    // Operand capture on start, then one algorithm step per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy    <= 1'b0;
            mode_q  <= MODE_MUL;
            step    <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            rem     <= '0;
            quo     <= '0;
            divisor <= '0;
        end else if (start) begin
            busy    <= 1'b1;
            mode_q  <= mode;
            step    <= '0;
            acc     <= '0;
            mcand   <= {{WIDTH{1'b0}}, a};
            mplier  <= b;
            rem     <= '0;
            quo     <= a;
            divisor <= b;
        end else if (busy) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            rem    <= rem_next;
            quo    <= quo_next;
            step   <= step + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Valid/ready front end for the 4-bit ALU. Single-cycle ops (logic, shift,
// add, subtract, DIV by zero, illegal opcodes) are evaluated at accept; MUL
// and DIV are handed to alu_iter_unit. Results and flags are registered and
// held until the consumer takes them.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               cin,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               flag_cb,
    output logic               flag_div0,
    output logic               flag_illegal
);

    state_t             state;
    logic               accept;
    logic               iterative;
    logic               b_zero;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   r_low;
    logic [2*WIDTH-1:0] q_result;
    logic               q_cb;
    logic               q_div0;
    logic               q_illegal;

    logic               iter_done;
    logic [2*WIDTH-1:0] iter_result;
    iter_mode_t         iter_mode;

    // Handshake and request classification.
    always_comb begin
        in_ready  = (state == IDLE) && !reset;
        accept    = in_valid && in_ready;
        b_zero    = (b == '0);
        iterative = needs_iteration(op, b_zero);
        iter_mode = (op == OP_DIV) ? MODE_DIV : MODE_MUL;
    end

    // Single-cycle datapath. The subtract's extra top bit is the sign of
    // a - b - cin, which is exactly the borrow-out.
    always_comb begin
        sum       = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        diff      = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
        r_low     = '0;
        q_cb      = 1'b0;
        q_div0    = 1'b0;
        q_illegal = 1'b0;
        q_result  = '0;
        case (op)
            OP_AND:  r_low = a & b;
            OP_NAND: r_low = ~(a & b);
            OP_OR:   r_low = a | b;
            OP_NOR:  r_low = ~(a | b);
            OP_XOR:  r_low = a ^ b;
            OP_XNOR: r_low = ~(a ^ b);
            OP_NOT:  r_low = ~a;
            OP_SHL:  r_low = {a[WIDTH-2:0], 1'b0};
            OP_ADD: begin
                r_low = sum[WIDTH-1:0];
                q_cb  = sum[WIDTH];
            end
            OP_SUB: begin
                r_low = diff[WIDTH-1:0];
                q_cb  = diff[WIDTH];
            end
            default: begin
                r_low     = '0;
                q_illegal = is_illegal_op(op);
            end
        endcase
        if ((op == OP_DIV) && b_zero) begin
            q_result = {a, {WIDTH{1'b1}}};
            q_div0   = 1'b1;
        end else begin
            q_result = {{WIDTH{1'b0}}, r_low};
        end
    end

    alu_iter_unit #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk    (clk),
        .reset  (reset),
        .start  (accept && iterative),
        .mode   (iter_mode),
        .a      (a),
        .b      (b),
        .done   (iter_done),
        .result (iter_result)
    );

    // Sequencer FSM with registered result, flags and out_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            out_valid    <= 1'b0;
            result       <= '0;
            flag_cb      <= 1'b0;
            flag_div0    <= 1'b0;
            flag_illegal <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (iterative) begin
                            state <= ITER;
                        end else begin
                            result       <= q_result;
                            flag_cb      <= q_cb;
                            flag_div0    <= q_div0;
                            flag_illegal <= q_illegal;
                            out_valid    <= 1'b1;
                            state        <= DONE;
                        end
                    end
                end
                ITER: begin
                    if (iter_done) begin
                        result       <= iter_result;
                        flag_cb      <= 1'b0;
                        flag_div0    <= 1'b0;
                        flag_illegal <= 1'b0;
                        out_valid    <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: a transaction-level reference
// model compared against the DUT every cycle, directed cases with literal
// expectations, then randomized traffic with backpressure and reset pulses.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       flag_cb;
    logic       flag_div0;
    logic       flag_illegal;

    int checks = 0;
    int errors = 0;

    alu_op_sequencer #(
        .WIDTH (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .op           (op),
        .a            (a),
        .b            (b),
        .cin          (cin),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .flag_cb      (flag_cb),
        .flag_div0    (flag_div0),
        .flag_illegal (flag_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Arithmetic definition of every opcode.
    function automatic void ref_op(input logic [3:0] o, input logic [3:0] x, input logic [3:0] y,
                                   input logic c, output logic [7:0] r,
                                   output logic cb, output logic dz, output logic il);
        int s;
        r  = 8'h00;
        cb = 1'b0;
        dz = 1'b0;
        il = 1'b0;
        case (o)
            4'd0:  r = {4'h0, x & y};
            4'd1:  r = {4'h0, ~(x & y)};
            4'd2:  r = {4'h0, x | y};
            4'd3:  r = {4'h0, ~(x | y)};
            4'd4:  r = {4'h0, x ^ y};
            4'd5:  r = {4'h0, ~(x ^ y)};
            4'd6:  r = {4'h0, ~x};
            4'd7:  r = 8'((int'(x) * 2) % 16);
            4'd8: begin
                s  = int'(x) + int'(y) + int'(c);
                r  = 8'(s % 16);
                cb = (s > 15);
            end
            4'd9: begin
                s  = int'(x) - int'(y) - int'(c);
                r  = 8'((s + 32) % 16);
                cb = (int'(x) < int'(y) + int'(c));
            end
            4'd10: r = 8'(int'(x) * int'(y));
            4'd11: begin
                if (y == 4'h0) begin
                    r  = {x, 4'hF};
                    dz = 1'b1;
                end else begin
                    r = 8'((int'(x) % int'(y)) * 16 + int'(x) / int'(y));
                end
            end
            default: il = 1'b1;
        endcase
    endfunction

    // Reference model: idle / computing (countdown) / holding a result.
    bit         m_busy = 1'b0;
    bit         m_hold = 1'b0;
    int         m_left = 0;
    logic [7:0] m_res  = 8'h00;
    logic       m_cb   = 1'b0;
    logic       m_dz   = 1'b0;
    logic       m_il   = 1'b0;
    logic [7:0] p_res;
    logic       p_cb, p_dz, p_il;

    always @(posedge clk) begin
        if (reset) begin
            m_busy = 1'b0;
            m_hold = 1'b0;
            m_res  = 8'h00;
            m_cb   = 1'b0;
            m_dz   = 1'b0;
            m_il   = 1'b0;
        end else if (m_hold) begin
            if (out_ready) m_hold = 1'b0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0;
                m_hold = 1'b1;
                m_res  = p_res;
                m_cb   = p_cb;
                m_dz   = p_dz;
                m_il   = p_il;
            end
        end else if (in_valid) begin
            ref_op(op, a, b, cin, p_res, p_cb, p_dz, p_il);
            if (op == 4'd10 || (op == 4'd11 && b != 4'h0)) begin
                m_busy = 1'b1;
                m_left = 4;
            end else begin
                m_hold = 1'b1;
                m_res  = p_res;
                m_cb   = p_cb;
                m_dz   = p_dz;
                m_il   = p_il;
            end
        end
    end

    // Every-cycle comparison, sampled 1 time unit after the rising edge.
    always begin
        @(posedge clk);
        #1;
        chk("in_ready",     32'(in_ready),     32'(!reset && !m_busy && !m_hold));
        chk("out_valid",    32'(out_valid),    32'(m_hold));
        chk("result",       32'(result),       32'(m_res));
        chk("flag_cb",      32'(flag_cb),      32'(m_cb));
        chk("flag_div0",    32'(flag_div0),    32'(m_dz));
        chk("flag_illegal", 32'(flag_illegal), 32'(m_il));
    end

    // Directed transaction with literal expectations; operands are scrambled
    // right after accept to show they are not resampled.
    task automatic do_op(input string name, input logic [3:0] o, input logic [3:0] x,
                         input logic [3:0] y, input logic c, input logic [7:0] exp_r,
                         input int exp_lat, input logic ecb, input logic edz, input logic eil);
        int lat;
        @(negedge clk);
        chk({"rdy_", name}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        op        = o;
        a         = x;
        b         = y;
        cin       = c;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        op       = 4'($urandom);
        a        = 4'($urandom);
        b        = 4'($urandom);
        cin      = 1'($urandom);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({"lat_", name}, 32'(lat), 32'(exp_lat));
        chk({"res_", name}, 32'(result), 32'(exp_r));
        chk({"cb_", name},  32'(flag_cb), 32'(ecb));
        chk({"dz_", name},  32'(flag_div0), 32'(edz));
        chk({"il_", name},  32'(flag_illegal), 32'(eil));
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        op        = 4'h0;
        a         = 4'h0;
        b         = 4'h0;
        cin       = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result",    32'(result),    32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        do_op("add",  4'd8,  4'hC, 4'h3, 1'b1, 8'h00, 1, 1'b1, 1'b0, 1'b0);
        do_op("sub",  4'd9,  4'h3, 4'h1, 1'b1, 8'h01, 1, 1'b0, 1'b0, 1'b0);
        do_op("mul",  4'd10, 4'hF, 4'hF, 1'b0, 8'hE1, 5, 1'b0, 1'b0, 1'b0);
        do_op("div",  4'd11, 4'hD, 4'h4, 1'b0, 8'h13, 5, 1'b0, 1'b0, 1'b0);
        do_op("div0", 4'd11, 4'h9, 4'h0, 1'b0, 8'h9F, 1, 1'b0, 1'b1, 1'b0);
        do_op("ill",  4'hE,  4'h5, 4'h6, 1'b1, 8'h00, 1, 1'b0, 1'b0, 1'b1);
        do_op("sub_borrow", 4'd9, 4'h2, 4'h2, 1'b1, 8'h0F, 1, 1'b1, 1'b0, 1'b0);

        // Backpressure: XOR held for 3 cycles while an ADD waits.
        @(negedge clk);
        in_valid  = 1'b1;
        op        = 4'd4;
        a         = 4'hA;
        b         = 4'h5;
        cin       = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        op = 4'd8;
        a  = 4'h3;
        b  = 4'h4;
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid",    32'(out_valid), 32'd1);
            chk("bp_result",   32'(result),    32'h0F);
            chk("bp_in_ready", 32'(in_ready),  32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_retired_valid", 32'(out_valid), 32'd0);
        chk("bp_retired_ready", 32'(in_ready),  32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_add_valid",  32'(out_valid), 32'd1);
        chk("bp_add_result", 32'(result),    32'h07);

        // Reset pulse in the middle of a multiply.
        @(negedge clk);
        in_valid = 1'b1;
        op       = 4'd10;
        a        = 4'h7;
        b        = 4'h6;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("abort_valid",  32'(out_valid), 32'd0);
            chk("abort_result", 32'(result),    32'd0);
            @(negedge clk);
        end
        do_op("mul_after_rst", 4'd10, 4'h2, 4'h3, 1'b0, 8'h06, 5, 1'b0, 1'b0, 1'b0);

        // Back-to-back single-cycle ops.
        do_op("not", 4'd6, 4'h5, 4'h0, 1'b0, 8'h0A, 1, 1'b0, 1'b0, 1'b0);
        do_op("shl", 4'd7, 4'h9, 4'h3, 1'b1, 8'h02, 1, 1'b0, 1'b0, 1'b0);

        // Randomized traffic checked by the every-cycle comparison.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            reset     = ($urandom_range(0, 59) == 0);
            in_valid  = 1'($urandom);
            op        = 4'($urandom_range(0, 15));
            a         = 4'($urandom);
            b         = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom);
            cin       = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
